instruction_fetch: RTL and testbench

Fetch stage of the 22-bit pipelined processor. Holds the program counter and drives the word address into the combinational instruction memory. Captures the returned instruction into the IF/ID pipeline register with a valid bit. Handles stall, flush and taken-branch redirect from downstream stages, and keeps a retired-fetch counter for debug.

---
 rtl/instruction_fetch.sv | 161 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage of the 22-bit pipelined processor.
// Holds the program counter, addresses the combinational instruction memory and
// registers the returned word into IF/ID together with its PC, PC+4 and a valid bit.
// Taken branches override flush and stall. A flush alone only kills the IF/ID
// entry. A stall alone freezes everything. A debug counter tracks captured
// instructions.
module instruction_fetch #(
    parameter logic [21:0] RESET_PC = 22'h0,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [21:0]      branch_target,
    output logic [21:0]      imem_addr,
    input  logic [21:0]      imem_rd,
    output logic [21:0]      if_instr,
    output logic [21:0]      if_pc,
    output logic [21:0]      if_pc_plus4,
    output logic             if_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Per-edge control decoded from the state and the downstream requests
    logic        capture;
    logic        advance;
    logic        load_br;
    logic        clr_valid;

    logic [21:0] pc;

    // 22-bit unsigned PC increment, silently wraps past 22'h3FFFFC
    function automatic logic [21:0] pc_inc(input logic [21:0] a);
        return a + 22'd4;
    endfunction

    // Word-align a redirect target; the low bits only feed the misalign flag
    function automatic logic [21:0] pc_align(input logic [21:0] a);
        return {a[21:2], 2'b00};
    endfunction

    // The memory sees the PC register directly, never the inputs
    assign imem_addr = pc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-edge control, priority branch > flush > stall > fetch
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        advance   = 1'b0;
        load_br   = 1'b0;
        clr_valid = 1'b0;
        case (state)
            BOOT: begin
                // Settle cycle: nothing is captured, a redirect is still honoured
                state_nxt = FETCH;
                load_br   = branch_taken;
                clr_valid = branch_taken;
            end
            FETCH, HOLD: begin
                if (branch_taken) begin
                    load_br   = 1'b1;
                    clr_valid = 1'b1;
                    state_nxt = FETCH;
                end else if (flush) begin
                    // The word fetched this cycle is dropped; PC obeys stall
                    clr_valid = 1'b1;
                    if (stall) begin
                        state_nxt = HOLD;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = FETCH;
                    end
                end else if (stall) begin
                    state_nxt = HOLD;
                end else begin
                    capture   = 1'b1;
                    advance   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // Program counter: redirect wins over sequential advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load_br) begin
            pc <= pc_align(branch_target);
        end else if (advance) begin
            pc <= pc_inc(pc);
        end
    end

    // IF/ID register: instruction, its address and the fall-through address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_instr    <= 22'h0;
            if_pc       <= 22'h0;
            if_pc_plus4 <= 22'h0;
        end else if (capture) begin
            if_instr    <= imem_rd;
            if_pc       <= pc;
            if_pc_plus4 <= pc_inc(pc);
        end
    end

    // IF/ID valid bit: set by a capture, cleared by flush or redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
        end else if (capture) begin
            if_valid <= 1'b1;
        end else if (clr_valid) begin
            if_valid <= 1'b0;
        end
    end

    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (load_br && (branch_target[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end

    // Debug counter of captured instructions, wraps at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (capture) begin
            fetch_count <= fetch_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed reset/fetch sequence, a vector table of
// stall/flush/branch/wrap cases, an asynchronous reset mid-run, then random
// stimulus checked against a behavioural model of the fetch stage.
module tb_instruction_fetch;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             branch_taken = 1'b0;
    logic [21:0]      branch_target = 22'h0;
    logic [21:0]      imem_addr;
    logic [21:0]      imem_rd;
    logic [21:0]      if_instr;
    logic [21:0]      if_pc;
    logic [21:0]      if_pc_plus4;
    logic             if_valid;
    logic             misalign_err;
    logic [CNT_W-1:0] fetch_count;

    int checks = 0;
    int failures = 0;

    instruction_fetch #(.RESET_PC(22'h0), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_rd      (imem_rd),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc_plus4  (if_pc_plus4),
        .if_valid     (if_valid),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: program words at 0..3, a hash of the word address elsewhere
    function automatic logic [21:0] memf(input logic [21:0] a);
        logic [19:0] w;
        w = a[21:2];
        case (w)
            20'd0, 20'd1: return 22'b1001101000000010001000;
            20'd2:        return 22'b1001101000000100001001;
            20'd3:        return 22'b1000000000100000010000;
            default:      return {w[3:2], w ^ 20'hA5C3B};
        endcase
    endfunction

    assign imem_rd = memf(imem_addr);

    // Behavioural model of the fetch stage
    logic             m_boot;
    logic [21:0]      m_pc;
    logic [21:0]      m_instr;
    logic [21:0]      m_ipc;
    logic [21:0]      m_p4;
    logic             m_valid;
    logic             m_err;
    logic [CNT_W-1:0] m_cnt;

    task automatic model_reset();
        m_boot  = 1'b1;
        m_pc    = 22'h0;
        m_instr = 22'h0;
        m_ipc   = 22'h0;
        m_p4    = 22'h0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_cnt   = '0;
    endtask

    task automatic model_edge(input logic s, input logic f, input logic b, input logic [21:0] t);
        if (b) begin
            m_pc    = t & 22'h3FFFFC;
            m_valid = 1'b0;
            if (t % 4 != 0) m_err = 1'b1;
        end else if (m_boot) begin
            // settle cycle, nothing changes
        end else if (f) begin
            m_valid = 1'b0;
            if (!s) m_pc = 22'((int'(m_pc) + 4) % (1 << 22));
        end else if (!s) begin
            m_instr = memf(m_pc);
            m_ipc   = m_pc;
            m_p4    = 22'((int'(m_pc) + 4) % (1 << 22));
            m_valid = 1'b1;
            m_cnt   = CNT_W'((int'(m_cnt) + 1) % (1 << CNT_W));
            m_pc    = m_p4;
        end
        m_boot = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'(m_pc));
        chk({tag, "_if_instr"}, 32'(if_instr), 32'(m_instr));
        chk({tag, "_if_pc"}, 32'(if_pc), 32'(m_ipc));
        chk({tag, "_if_pc_plus4"}, 32'(if_pc_plus4), 32'(m_p4));
        chk({tag, "_if_valid"}, 32'(if_valid), 32'(m_valid));
        chk({tag, "_misalign_err"}, 32'(misalign_err), 32'(m_err));
        chk({tag, "_fetch_count"}, 32'(fetch_count), 32'(m_cnt));
    endtask

    task automatic step(input logic s, input logic f, input logic b, input logic [21:0] t,
                        input string tag);
        stall         = s;
        flush         = f;
        branch_taken  = b;
        branch_target = t;
        @(posedge clk);
        #1;
        model_edge(s, f, b, t);
        check_model(tag);
    endtask

    task automatic do_reset();
        #2;
        rst_n         = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 22'h0;
        #1;
        model_reset();
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_instr", 32'(if_instr), 32'h0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0);
        chk("rst_fetch_count", 32'(fetch_count), 32'h0);
        chk("rst_misalign", 32'(misalign_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        s;
        logic        f;
        logic        b;
        logic [21:0] t;
        logic        v;
        logic [21:0] ipc;
        logic [21:0] addr;
        logic [15:0] cnt;
        logic        err;
    } vec_t;

    vec_t tbl[18];

    initial begin
        // s  f  b  target        valid if_pc        imem_addr     count  err
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 22'h0,      1'b0, 22'h0,      22'h0,      16'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 22'h0,      1'b1, 22'h0,      22'h4,      16'd1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 22'h0,      1'b1, 22'h4,      22'h8,      16'd2, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 22'h0,      1'b1, 22'h4,      22'h8,      16'd2, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 22'h0,      1'b1, 22'h4,      22'h8,      16'd2, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 22'h0,      1'b1, 22'h4,      22'h8,      16'd2, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 22'h0,      1'b1, 22'h8,      22'hC,      16'd3, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 22'h20,     1'b0, 22'h8,      22'h20,     16'd3, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 22'h0,      1'b1, 22'h20,     22'h24,     16'd4, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 22'h0,      1'b0, 22'h20,     22'h24,     16'd4, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 22'h0,      1'b0, 22'h20,     22'h24,     16'd4, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 22'h0,      1'b1, 22'h24,     22'h28,     16'd5, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 22'h22,     1'b0, 22'h24,     22'h20,     16'd5, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 22'h0,      1'b1, 22'h20,     22'h24,     16'd6, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 22'h3FFFFC, 1'b0, 22'h20,     22'h3FFFFC, 16'd6, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 22'h0,      1'b1, 22'h3FFFFC, 22'h0,      16'd7, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 22'h0,      1'b1, 22'h0,      22'h4,      16'd8, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 22'h0,      1'b0, 22'h0,      22'h8,      16'd8, 1'b1};

        // Reset and sequential fetch of the small program
        do_reset();
        step(1'b0, 1'b0, 1'b0, 22'h0, "seq1");
        chk("seq_boot_no_capture", 32'(if_valid), 32'h0);
        step(1'b0, 1'b0, 1'b0, 22'h0, "seq2");
        chk("seq_e2_instr", 32'(if_instr), 32'(22'b1001101000000010001000));
        chk("seq_e2_pc", 32'(if_pc), 32'h0);
        chk("seq_e2_pc4", 32'(if_pc_plus4), 32'h4);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 22'h0, "seq");
        chk("seq_e5_pc", 32'(if_pc), 32'hC);
        chk("seq_e5_count", 32'(fetch_count), 32'd4);
        chk("seq_e5_instr", 32'(if_instr), 32'(22'b1000000000100000010000));

        // Vector table: stall, branch under stall, flush under stall, misalign, wrap
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].s, tbl[i].f, tbl[i].b, tbl[i].t, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d_if_pc", i), 32'(if_pc), 32'(tbl[i].ipc));
            chk($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
            chk($sformatf("vec%0d_count", i), 32'(fetch_count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_err", i), 32'(misalign_err), 32'(tbl[i].err));
            if (i == 8) chk("vec8_target_instr", 32'(if_instr), 32'(memf(22'h20)));
            if (i == 15) chk("vec15_wrap_pc4", 32'(if_pc_plus4), 32'h0);
        end

        // Asynchronous reset between edges while IF/ID is valid
        step(1'b0, 1'b0, 1'b0, 22'h0, "pre_arst");
        step(1'b0, 1'b0, 1'b0, 22'h0, "pre_arst");
        chk("arst_pre_valid", 32'(if_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(if_valid), 32'h0);
        chk("arst_count", 32'(fetch_count), 32'h0);
        chk("arst_pc", 32'(imem_addr), 32'h0);
        chk("arst_err", 32'(misalign_err), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random stimulus against the model
        for (int n = 0; n < 600; n++) begin
            logic        rs;
            logic        rf;
            logic        rb;
            logic [21:0] rt;
            rs = ($urandom % 4) == 0;
            rf = ($urandom % 6) == 0;
            rb = ($urandom % 8) == 0;
            rt = 22'($urandom);
            if (($urandom % 3) == 0) rt = 22'h3FFFF0 | 22'($urandom % 16);
            step(rs, rf, rb, rt, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
